// File: rtl/nn_pkg.sv
// Shared fixed-point definitions and types for the perceptron training datapath.
package nn_pkg;

  localparam int SIGN = 1;
  localparam int Q_M  = 15;
  localparam int Q_N  = 16;
  localparam int W    = SIGN + Q_M + Q_N;

  typedef struct packed {
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] out;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_t;

endpackage

// File: rtl/sample_table.sv
// Training sample register file: one write port, asynchronous read port with
// write-first bypass so a same-cycle write is visible on a matching read.
module sample_table
  import nn_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int ADDR_W      = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  sample_t           wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output sample_t           rd_data_o
);

  sample_t mem_q [NUM_SAMPLES];
  logic    wr_hit_s;
  logic    rd_in_range_s;

  assign wr_hit_s      = wr_en_i && (32'(wr_addr_i) < 32'(NUM_SAMPLES));
  assign rd_in_range_s = 32'(rd_addr_i) < 32'(NUM_SAMPLES);

  // Table storage; cleared on reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_hit_s) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read with write-first bypass.
  always_comb begin
    rd_data_o = '0;
    if (wr_hit_s && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end else if (rd_in_range_s) begin
      rd_data_o = mem_q[rd_addr_i];
    end else begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/training_sample_streamer.sv
// Streams the sample table to the neuron trainer over valid/ready for
// TRAIN_ITERATIONS epochs, then pulses done_o.
module training_sample_streamer #(
  parameter int  NUM_SAMPLES      = 4,
  parameter int  TRAIN_ITERATIONS = 10,
  parameter int  SIGN             = 1,
  parameter int  Q_M              = 15,
  parameter int  Q_N              = 16,
  localparam int DW               = SIGN + Q_M + Q_N,
  localparam int ADDR_W           = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DW-1:0]     wr_x1_i,
  input  logic [DW-1:0]     wr_x2_i,
  input  logic [DW-1:0]     wr_out_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [DW-1:0]     train_x1_o,
  output logic [DW-1:0]     train_x2_o,
  output logic [DW-1:0]     train_out_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              epoch_last_o,
  output logic [15:0]       epoch_o,
  output logic              busy_o,
  output logic              done_o
);
  import nn_pkg::*;

  if (TRAIN_ITERATIONS > 65535 || TRAIN_ITERATIONS < 0) begin : g_iter_chk
    $error("TRAIN_ITERATIONS must be in 0..65535");
  end
  if (NUM_SAMPLES < 1) begin : g_num_chk
    $error("NUM_SAMPLES must be >= 1");
  end
  if (DW != W) begin : g_width_chk
    $error("SIGN+Q_M+Q_N must match the package word width");
  end

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [15:0]       LAST_EPOCH = 16'((TRAIN_ITERATIONS > 0) ? TRAIN_ITERATIONS - 1 : 0);
  localparam logic              ONE_SAMPLE = 1'(NUM_SAMPLES == 1);

  stream_state_t     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, rd_addr_s;
  logic [15:0]       epoch_q, epoch_d;
  sample_t           sample_q, sample_d, rd_data_s, wr_data_s;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_en_s;

  // The table is frozen while a run is streaming.
  assign wr_en_s   = wr_en_i && (state_q != STREAM);
  assign wr_data_s = {wr_x1_i, wr_x2_i, wr_out_i};

  sample_table #(
    .NUM_SAMPLES (NUM_SAMPLES),
    .ADDR_W      (ADDR_W)
  ) u_table (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_en_i   (wr_en_s),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_s),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (rd_data_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    epoch_d   = epoch_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_addr_s = idx_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        if (start_i) begin
          idx_d     = '0;
          epoch_d   = 16'd0;
          rd_addr_s = '0;
          if (TRAIN_ITERATIONS == 0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = STREAM;
            sample_d = rd_data_s;
            valid_d  = 1'b1;
            last_d   = ONE_SAMPLE;
            busy_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (abort_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (valid_q && ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d     = '0;
            rd_addr_s = '0;
            if (epoch_q == LAST_EPOCH) begin
              state_d = DONE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              epoch_d  = epoch_q + 16'd1;
              sample_d = rd_data_s;
              last_d   = ONE_SAMPLE;
            end
          end else begin
            idx_d     = idx_q + ADDR_W'(1);
            rd_addr_s = idx_q + ADDR_W'(1);
            sample_d  = rd_data_s;
            last_d    = ((idx_q + ADDR_W'(1)) == LAST_IDX);
          end
        end else begin
          state_d = STREAM;
        end
      end
      DONE: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      epoch_q  <= 16'd0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      epoch_q  <= epoch_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign train_x1_o   = sample_q.x1;
  assign train_x2_o   = sample_q.x2;
  assign train_out_o  = sample_q.out;
  assign valid_o      = valid_q;
  assign epoch_last_o = last_q;
  assign epoch_o      = epoch_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
